// File: rtl/byte_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// byte_serial_add_ctrl
//
// Purpose:
//   Sequencer around an external WIDTH-bit ripple-carry adder. It accepts a
//   multi-byte addition as a stream of operand byte pairs, least-significant
//   byte first. The carry is chained between bytes in a carry register. Each
//   sum byte is placed on an output stream, and the packet carry-out is
//   flagged on the last byte.
//
//   Pipeline:
//     stage 1 : operand register (op_*), which drives the adder
//     stage 2 : output register (out_*)
//
// Optional feature (macro BSAC_OVF_EN):
//   When defined, the block adds the output out_ovf. This flag reports the
//   signed two's-complement overflow of the whole packet. It is registered on
//   the last byte only and is 0 on all other bytes.
//
// Ports:
//   clk        in   clock; all logic runs on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand byte pair valid
//   in_ready   out  block can accept an operand byte pair (0 during reset)
//   in_a/in_b  in   operand bytes
//   in_first   in   first (least-significant) byte of a packet
//   in_last    in   last (most-significant) byte of a packet
//   in_cin     in   packet carry-in, used only with in_first
//   add_a/b    out  adder operands
//   add_cin    out  adder carry-in
//   add_sum    in   adder sum
//   add_cout   in   adder carry-out
//   out_valid  out  result byte valid
//   out_ready  in   downstream accepts the result byte
//   out_sum    out  result byte
//   out_last   out  last byte of the result packet
//   out_cout   out  packet carry-out; non-zero only when out_last=1
//   out_idx    out  byte index within the packet
//   out_ovf    out  signed overflow on the last byte (BSAC_OVF_EN only)
//   err        out  sticky protocol/length error
//   err_clr    in   clears err; a simultaneous error set wins
//   dbg_state  out  current FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake semantics (both streams):
//   A transfer happens on a rising edge where valid && ready. Once a producer
//   raises valid, it holds valid and its data stable until the transfer.
//   While out_valid=1 and out_ready=0, every out_* signal holds stable.
// -----------------------------------------------------------------------------
module byte_serial_add_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MAX_BYTES = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // operand stream
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic                         in_cin,
  // adder interface
  output logic [WIDTH-1:0]             add_a,
  output logic [WIDTH-1:0]             add_b,
  output logic                         add_cin,
  input  logic [WIDTH-1:0]             add_sum,
  input  logic                         add_cout,
  // result stream
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_sum,
  output logic                         out_last,
  output logic                         out_cout,
  output logic [$clog2(MAX_BYTES)-1:0] out_idx,
`ifdef BSAC_OVF_EN
  output logic                         out_ovf,
`endif
  // error and debug
  output logic                         err,
  input  logic                         err_clr,
  output logic                         dbg_state
);

  localparam int IDXW = $clog2(MAX_BYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MAX_BYTES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // FSM
  state_t            r_state;
  state_t            w_state_nxt;

  // stage 1: operand register
  logic              r_op_valid;
  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic              r_op_first;
  logic              r_op_last;
  logic              r_op_cin;
  logic [IDXW-1:0]   r_op_idx;

  // inter-byte carry
  logic              r_carry;

  // stage 2: output register
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_sum;
  logic              r_out_last;
  logic              r_out_cout;
  logic [IDXW-1:0]   r_out_idx;

  logic              r_err;

  // handshake and per-byte decode
  logic              w_advance;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_set_err;
  logic              w_first;
  logic              w_last;
  logic              w_cin;
  logic [IDXW-1:0]   w_idx;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // Stage 1 moves into stage 2 when stage 2 is empty or is being drained in
  // this same cycle.
  assign w_advance  = r_op_valid && (!r_out_valid || out_ready);
  // Stage 1 can take a new byte when it is empty or when it is moving on.
  // rst_n gates this signal so nothing is accepted during reset.
  assign in_ready   = rst_n && (!r_op_valid || w_advance);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Adder drive: driven only from stage-1 registers.
  // ---------------------------------------------------------------------------
  assign add_a   = r_op_a;
  assign add_b   = r_op_b;
  assign add_cin = r_op_first ? r_op_cin : r_carry;

  // ---------------------------------------------------------------------------
  // FSM next state and decode of the byte being accepted.
  // r_op_idx always holds the index of the most recently accepted byte.
  // Stage 1 loads only on an input transfer, so r_op_idx is the predecessor
  // of the byte now being accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b1;
    w_last      = in_last;
    w_cin       = 1'b0;
    w_idx       = '0;
    w_set_err   = 1'b0;

    if (w_in_xfer) begin
      case (r_state)
        S_IDLE: begin
          // A packet has to open with in_first. If it does not, the byte
          // is flagged and still used as a first byte, with carry-in 0.
          if (in_first) begin
            w_cin = in_cin;
          end else begin
            w_set_err = 1'b1;
          end
        end
        S_BUSY: begin
          if (in_first) begin
            // Restart. The previous packet is abandoned without a last byte.
            w_set_err = 1'b1;
            w_cin     = in_cin;
          end else begin
            w_first = 1'b0;
            w_idx   = r_op_idx + IDXW'(1);
          end
        end
        default: begin
          w_set_err = 1'b0;
        end
      endcase

      // Length limit: the final index slot must close the packet.
      if ((w_idx == LAST_IDX) && !in_last) begin
        w_set_err = 1'b1;
        w_last    = 1'b1;
      end

      w_state_nxt = w_last ? S_IDLE : S_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: operand register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_valid <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_op_first <= 1'b0;
      r_op_last  <= 1'b0;
      r_op_cin   <= 1'b0;
      r_op_idx   <= '0;
    end else if (w_in_xfer) begin
      r_op_valid <= 1'b1;
      r_op_a     <= in_a;
      r_op_b     <= in_b;
      r_op_first <= w_first;
      r_op_last  <= w_last;
      r_op_cin   <= w_cin;
      r_op_idx   <= w_idx;
    end else if (w_advance) begin
      r_op_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: output register and carry chain
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
      r_out_idx   <= '0;
      r_carry     <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= add_sum;
      r_out_last  <= r_op_last;
      r_out_cout  <= r_op_last ? add_cout : 1'b0;
      r_out_idx   <= r_op_idx;
      // The carry register is cleared on a last byte, so no carry leaks
      // into the next packet.
      r_carry     <= r_op_last ? 1'b0 : add_cout;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef BSAC_OVF_EN
  // Signed overflow of the whole packet. It depends only on the sign bits of
  // the most-significant byte, so it is evaluated on the last byte.
  logic r_out_ovf;
  logic w_ovf;

  assign w_ovf = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                 (add_sum[WIDTH-1] != r_op_a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_ovf <= 1'b0;
    end else if (w_advance) begin
      r_out_ovf <= r_op_last ? w_ovf : 1'b0;
    end
  end

  assign out_ovf = r_out_ovf;
`endif

  // ---------------------------------------------------------------------------
  // Sticky error: a set beats a simultaneous clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_last  = r_out_last;
  assign out_cout  = r_out_cout;
  assign out_idx   = r_out_idx;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_serial_add_ctrl
//
// Directed bench for byte_serial_add_ctrl, with MAX_BYTES=4 so the length
// limit is reachable. A behavioural 8-bit adder stands in for the external
// ripple-carry adder. Each accepted output byte is captured as a record
// {ovf, last, cout, idx[1:0], sum[7:0]}. Each test pushes hand-computed
// records onto exp_q and compares them in order.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// after the falling edge.
// -----------------------------------------------------------------------------
module tb_byte_serial_add_ctrl;

  localparam int REC_W = 13;
`ifdef BSAC_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- DUT signals
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       in_first = 1'b0;
  logic       in_last = 1'b0;
  logic       in_cin = 1'b0;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_last;
  logic       out_cout;
  logic [1:0] out_idx;
  logic       err;
  logic       err_clr = 1'b0;
  logic       dbg_state;
`ifdef BSAC_OVF_EN
  logic       out_ovf;
  wire        ovf_bit = out_ovf;
`else
  wire        ovf_bit = 1'b0;
`endif

  // behavioural model of the external adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  byte_serial_add_ctrl #(.WIDTH(8), .MAX_BYTES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_idx   (out_idx),
`ifdef BSAC_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .err       (err),
    .err_clr   (err_clr),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int failures = 0;
  int n_in_acc = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] obs_q[$];
  int               obs_cyc_q[$];

  // Records output transfers and counts input transfers. The cycle pushed
  // is the posedge count at which the output transfer completes.
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) begin
      obs_q.push_back({ovf_bit, out_last, out_cout, out_idx, out_sum});
      obs_cyc_q.push_back(cyc + 1);
    end
    if (in_valid && in_ready) n_in_acc++;
  end

  function automatic logic [REC_W-1:0] mk(input logic ovf, input logic last,
                                          input logic cout, input logic [1:0] idx,
                                          input logic [7:0] sum);
    return {ovf, last, cout, idx, sum};
  endfunction

  // ---------------------------------------------------------------- driver
  // Called on a falling edge. Presents one byte pair and returns on the
  // falling edge after it is accepted. in_valid stays high so callers can
  // stream bytes back to back. acc is the posedge count of the accept.
  task automatic send_byte(input logic [7:0] a, input logic [7:0] b,
                           input logic f, input logic l, input logic c,
                           output int acc);
    int n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_first = f;
    in_last = l;
    in_cin = c;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    acc = cyc + 1;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b required=0", in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_last, out_cout} !== 3'b000) begin
      failures++;
      $display("FAIL reset_out_flags got=%b required=000", {out_valid, out_last, out_cout});
    end
    checks++;
    if ({out_idx, out_sum} !== 10'h000) begin
      failures++;
      $display("FAIL reset_out_data got=%h required=000", {out_idx, out_sum});
    end
    checks++;
    if (err !== 1'b0 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_err_state got=%b%b required=00", err, dbg_state);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b required=1", in_ready);
    end
    @(negedge clk);
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // 0x01FF + 0x0001 -> 0x0200
  task automatic test_basic();
    int acc0, acc1;
    logic [REC_W-1:0] o, e;
    out_ready = 1'b1;
    send_byte(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, acc0);
    send_byte(8'h01, 8'h00, 1'b0, 1'b1, 1'b0, acc1);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (obs_cyc_q.size() < 2 || obs_cyc_q[0] - acc0 != 2 || obs_cyc_q[1] - acc1 != 2) begin
      failures++;
      $display("FAIL basic_latency got=%0d,%0d required=2,2 (n=%0d)",
               obs_cyc_q[0] - acc0, obs_cyc_q[1] - acc1, obs_cyc_q.size());
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd1, 8'h02));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic_byte got=%h required=%h", o, e);
      end
    end
    checks++;
    if (obs_q.size() != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_extra_or_err extra=%0d err=%b required=0,0", obs_q.size(), err);
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // 0xFFFF + 0x0001 -> carry out, then a single-byte packet must see no carry
  task automatic test_carry_chain();
    int acc;
    logic [REC_W-1:0] o, e;
    out_ready = 1'b1;
    send_byte(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, acc);
    send_byte(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    send_byte(8'h05, 8'h03, 1'b1, 1'b1, 1'b0, acc);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 2'd1, 8'h00));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 8'h08));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL carry_byte got=%h required=%h", o, e);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL carry_extra got=%0d required=0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // 0x80 + 0x80 + 1 -> 0x01, cout=1, signed overflow
  task automatic test_single_ovf();
    int acc;
    logic [REC_W-1:0] o, e;
    out_ready = 1'b1;
    send_byte(8'h80, 8'h80, 1'b1, 1'b1, 1'b1, acc);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    e = mk(OVF_ON, 1'b1, 1'b1, 2'd0, 8'h01);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL single_ovf_byte got=%h required=%h", o, e);
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // four bytes 0x11+0x22 under a 3-cycle stall of out_ready
  task automatic test_back_to_back();
    int acc, acc_before;
    logic [REC_W-1:0] o, e;
    out_ready = 1'b0;
    acc_before = n_in_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send_byte(8'h11, 8'h22, (i == 0), (i == 3), 1'b0, acc);
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          if (k >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 8'h33 || out_idx !== 2'd0) begin
              failures++;
              $display("FAIL bp_hold k=%0d got=%b/%h/%0d required=1/33/0",
                       k, out_valid, out_sum, out_idx);
            end
          end
        end
        checks++;
        if (n_in_acc - acc_before != 2 || in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_accepts got=%0d ready=%b required=2 ready=0",
                   n_in_acc - acc_before, in_ready);
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'b0, (i == 3), 1'b0, 2'(i), 8'h33));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bp_byte got=%h required=%h", o, e);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL bp_extra got=%0d required=0", obs_q.size());
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // in_first on the second byte restarts the packet with in_cin
  task automatic test_proto_err();
    int acc;
    logic [REC_W-1:0] o, e;
    out_ready = 1'b1;
    send_byte(8'h10, 8'h20, 1'b1, 1'b0, 1'b0, acc);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL proto_err_pre got=%b required=0", err);
    end
    send_byte(8'h01, 8'h02, 1'b1, 1'b0, 1'b1, acc);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL proto_err_set got=%b required=1", err);
    end
    send_byte(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h30));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h04));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd1, 8'hFF));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL proto_byte got=%h required=%h", o, e);
      end
    end
    err_clr = 1'b1;
    #1;
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL proto_err_sticky got=%b required=1", err);
    end
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL proto_err_clr got=%b required=0", err);
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // five bytes without in_last against MAX_BYTES=4
  task automatic test_len_err();
    int acc;
    logic [REC_W-1:0] o, e;
    out_ready = 1'b1;
    send_byte(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, acc);
    send_byte(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, acc);
    send_byte(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, acc);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL len_err_pre got=%b required=0", err);
    end
    send_byte(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, acc);
    checks++;
    if (err !== 1'b1 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL len_err_limit err=%b state=%b required=1,0", err, dbg_state);
    end
    // Fifth byte has no in_first and carries in_cin=1, which must be ignored.
    // err_clr is held in the same cycle, and the error set must win.
    err_clr = 1'b1;
    send_byte(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, acc);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b1 || dbg_state !== 1'b1) begin
      failures++;
      $display("FAIL len_err_idle_rule err=%b state=%b required=1,1", err, dbg_state);
    end
    send_byte(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h02));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd1, 8'h02));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd2, 8'h02));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 2'd3, 8'h00));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h02));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd1, 8'h00));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL len_byte got=%h required=%h", o, e);
      end
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // reset with two bytes in flight: nothing may come out afterwards
  task automatic test_reset_mid();
    int acc;
    logic [REC_W-1:0] o, e;
    out_ready = 1'b0;
    send_byte(8'h01, 8'h01, 1'b1, 1'b0, 1'b0, acc);
    send_byte(8'h02, 8'h02, 1'b0, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b0 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL rmid_state got=%b%b%b required=000", out_valid, err, dbg_state);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL rmid_partial got=%0d required=0", obs_q.size());
    end
    send_byte(8'h07, 8'h01, 1'b1, 1'b1, 1'b0, acc);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    e = mk(1'b0, 1'b1, 1'b0, 2'd0, 8'h08);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    checks++;
    if (o !== e || obs_q.size() != 0) begin
      failures++;
      $display("FAIL rmid_byte got=%h required=%h extra=%0d", o, e, obs_q.size());
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry_chain();
    test_single_ovf();
    test_back_to_back();
    test_proto_err();
    test_len_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
